// File: rtl/mxu_pkg.sv
// Shared MXU drain types and default geometry.
package mxu_pkg;

    localparam int unsigned MXU_ROWS   = 16;
    localparam int unsigned MXU_COLS   = 16;
    localparam int unsigned LSU_BEAT_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef enum logic {
        PREC_INT8  = 1'b0,
        PREC_INT16 = 1'b1
    } prec_e;

endpackage

// File: rtl/mxu_mask_next.sv
// Priority finder: lowest set mask bit above cur (or at cur when incl=1).
module mxu_mask_next #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned IDX_W = $clog2(ROWS)
) (
    input  logic [ROWS-1:0]  mask,
    input  logic [IDX_W-1:0] cur,
    input  logic             incl,
    output logic [IDX_W-1:0] nxt_idx_c,
    output logic             none_left_c
);

    // Scan downwards so the lowest qualifying index wins.
    always_comb begin
        nxt_idx_c   = '0;
        none_left_c = 1'b1;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (mask[i] && ((IDX_W'(i) > cur) || (incl && (IDX_W'(i) == cur)))) begin
                nxt_idx_c   = IDX_W'(i);
                none_left_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mxu_row_drain.sv
// Snapshots MXU row results and streams the masked rows to the LSU beat by beat.
module mxu_row_drain
    import mxu_pkg::*;
#(
    parameter int unsigned ROWS      = MXU_ROWS,
    parameter int unsigned COLS      = MXU_COLS,
    parameter int unsigned OUT_W     = LSU_BEAT_W,
    parameter int unsigned ROW_IDX_W = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap_vld,
    output logic                      cap_rdy,
    input  logic                      cap_mode,
    input  logic [ROWS-1:0]           cap_row_mask,
    input  logic [ROWS*COLS*8-1:0]    cap_int8_data,
    input  logic [ROWS*COLS*16-1:0]   cap_int16_data,
    input  logic                      clr,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [OUT_W-1:0]          out_pld,
    output logic [ROW_IDX_W-1:0]      out_row,
    output logic                      out_last,
    output logic                      done,
    output logic                      ovf
);

    localparam int unsigned ROW8_W  = COLS * 8;
    localparam int unsigned ROW16_W = COLS * 16;
    localparam int unsigned BUF_W   = ROWS * ROW16_W;
    localparam int unsigned OFF_W   = $clog2(BUF_W);
    localparam int unsigned BPR8    = ROW8_W / OUT_W;
    localparam int unsigned BPR16   = ROW16_W / OUT_W;
    localparam int unsigned BEAT_W  = (BPR16 > 1) ? $clog2(BPR16) : 1;

    drain_state_e           state_q, state_d;
    prec_e                  mode_q, mode_d;
    logic [ROWS-1:0]        mask_q, mask_d;
    logic [ROW_IDX_W-1:0]   row_q, row_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [BUF_W-1:0]       buf_q;
    logic [BUF_W-1:0]       cap_buf_c;
    logic                   take_c;
    logic                   done_d, ovf_d;
    logic                   cap_rdy_d, out_vld_d, out_last_d;
    logic [OUT_W-1:0]       out_pld_d;
    logic [ROW_IDX_W-1:0]   out_row_d;
    logic [ROW_IDX_W-1:0]   hi_row_c;
    logic [ROWS-1:0]        fnd_mask_c;
    logic [ROW_IDX_W-1:0]   fnd_cur_c;
    logic                   fnd_incl_c;
    logic [ROW_IDX_W-1:0]   fnd_idx_c;
    logic                   fnd_none_c;

    function automatic logic [BEAT_W-1:0] last_beat(input prec_e m);
        return (m == PREC_INT16) ? BEAT_W'(BPR16 - 1) : BEAT_W'(BPR8 - 1);
    endfunction

    // Int8 rows keep their native stride; upper buffer bits are unused in int8 mode.
    function automatic logic [OUT_W-1:0] beat_sel(input logic [BUF_W-1:0] src, input prec_e m,
                                                  input logic [ROW_IDX_W-1:0] r,
                                                  input logic [BEAT_W-1:0] b);
        logic [OFF_W-1:0] off;
        off = OFF_W'(32'(r) * ((m == PREC_INT16) ? ROW16_W : ROW8_W))
            + OFF_W'(32'(b) * OUT_W);
        return src[off +: OUT_W];
    endfunction

    assign cap_buf_c = cap_mode ? cap_int16_data : BUF_W'(cap_int8_data);

    // At capture search the incoming mask from row 0 inclusive, else step past the current row.
    always_comb begin
        fnd_mask_c = (state_q == IDLE) ? cap_row_mask : mask_q;
        fnd_cur_c  = (state_q == IDLE) ? '0 : row_q;
        fnd_incl_c = (state_q == IDLE);
    end

    mxu_mask_next #(
        .ROWS  (ROWS),
        .IDX_W (ROW_IDX_W)
    ) u_mask_next (
        .mask        (fnd_mask_c),
        .cur         (fnd_cur_c),
        .incl        (fnd_incl_c),
        .nxt_idx_c   (fnd_idx_c),
        .none_left_c (fnd_none_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and pointer logic; clr overrides capture and handshakes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        row_d   = row_q;
        beat_d  = beat_q;
        take_c  = 1'b0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cap_vld) begin
                        take_c = 1'b1;
                        mode_d = prec_e'(cap_mode);
                        mask_d = cap_row_mask;
                        beat_d = '0;
                        if (cap_row_mask == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            row_d   = fnd_idx_c;
                        end
                    end
                end
                DRAIN: begin
                    ovf_d = cap_vld;
                    if (out_rdy) begin
                        if (beat_q != last_beat(mode_q)) begin
                            beat_d = beat_q + BEAT_W'(1);
                        end else begin
                            beat_d = '0;
                            if (fnd_none_c) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                row_d = fnd_idx_c;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Highest masked row, used to flag the final beat.
    always_comb begin
        hi_row_c = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (mask_d[i]) hi_row_c = ROW_IDX_W'(i);
        end
    end

    // Output decode of the next state, registered below.
    always_comb begin
        cap_rdy_d  = (state_d == IDLE);
        out_vld_d  = (state_d == DRAIN);
        out_row_d  = '0;
        out_pld_d  = '0;
        out_last_d = 1'b0;
        if (state_d == DRAIN) begin
            out_row_d  = row_d;
            out_pld_d  = beat_sel(take_c ? cap_buf_c : buf_q, mode_d, row_d, beat_d);
            out_last_d = (row_d == hi_row_c) && (beat_d == last_beat(mode_d));
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= PREC_INT8;
            mask_q   <= '0;
            row_q    <= '0;
            beat_q   <= '0;
            cap_rdy  <= 1'b1;
            out_vld  <= 1'b0;
            out_pld  <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            row_q    <= row_d;
            beat_q   <= beat_d;
            cap_rdy  <= cap_rdy_d;
            out_vld  <= out_vld_d;
            out_pld  <= out_pld_d;
            out_row  <= out_row_d;
            out_last <= out_last_d;
            done     <= done_d;
            ovf      <= ovf_d;
        end
    end

    // Snapshot buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (take_c) buf_q <= cap_buf_c;
    end

endmodule

// File: tb/tb_mxu_row_drain.sv
// Directed bench for mxu_row_drain at default geometry (16 rows, 16 cols, 128-bit beats).
module tb_mxu_row_drain;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_vld;
    logic          cap_rdy;
    logic          cap_mode;
    logic [15:0]   cap_row_mask;
    logic [2047:0] cap_int8_data;
    logic [4095:0] cap_int16_data;
    logic          clr;
    logic          out_vld;
    logic          out_rdy;
    logic [127:0]  out_pld;
    logic [3:0]    out_row;
    logic          out_last;
    logic          done;
    logic          ovf;

    logic [2047:0] d8;
    logic [4095:0] d16;
    logic [127:0]  ep [64];
    int            er [64];
    bit            el [64];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    mxu_row_drain dut (
        .clk            (clk),
        .rst            (rst),
        .cap_vld        (cap_vld),
        .cap_rdy        (cap_rdy),
        .cap_mode       (cap_mode),
        .cap_row_mask   (cap_row_mask),
        .cap_int8_data  (cap_int8_data),
        .cap_int16_data (cap_int16_data),
        .clr            (clr),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_pld        (out_pld),
        .out_row        (out_row),
        .out_last       (out_last),
        .done           (done),
        .ovf            (ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_data(input int seed);
        for (int i = 0; i < 256; i++) begin
            d8[i*8 +: 8]    = 8'(i * 7 + seed);
            d16[i*16 +: 16] = 16'(i * 613 + seed * 3 + 1);
        end
    endtask

    task automatic cap(input bit mode, input logic [15:0] mask);
        cap_mode       = mode;
        cap_row_mask   = mask;
        cap_int8_data  = d8;
        cap_int16_data = d16;
        cap_vld        = 1'b1;
        tick();
        cap_vld        = 1'b0;
    endtask

    // Called right after the capture edge; checks every presented beat and the done pulse.
    task automatic run_drain(input bit mode, input logic [15:0] mask, input bit stall);
        int n, hi, bpr, idx, cyc;
        n   = 0;
        hi  = 0;
        bpr = mode ? 2 : 1;
        for (int r = 0; r < 16; r++) if (mask[r]) hi = r;
        for (int r = 0; r < 16; r++) begin
            if (mask[r]) begin
                for (int b = 0; b < bpr; b++) begin
                    ep[n] = mode ? d16[r*256 + b*128 +: 128] : d8[r*128 +: 128];
                    er[n] = r;
                    el[n] = (r == hi) && (b == bpr - 1);
                    n++;
                end
            end
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            chk("beat_vld", 128'(out_vld), 128'(1));
            chk("beat_pld", out_pld, ep[idx]);
            chk("beat_row", 128'(out_row), 128'(er[idx]));
            chk("beat_last", 128'(out_last), 128'(el[idx]));
            chk("beat_done_low", 128'(done), 128'(0));
            out_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_rdy) idx++;
            tick();
            cyc++;
        end
        out_rdy = 1'b1;
        chk("drain_beats", 128'(idx), 128'(n));
        chk("drain_done", 128'(done), 128'(1));
        chk("drain_vld_off", 128'(out_vld), 128'(0));
        chk("drain_cap_rdy", 128'(cap_rdy), 128'(1));
        tick();
        chk("done_one_cycle", 128'(done), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cap_vld = 1'b0; cap_mode = 1'b0; cap_row_mask = '0;
        cap_int8_data = '0; cap_int16_data = '0; clr = 1'b0; out_rdy = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cap_rdy", 128'(cap_rdy), 128'(1));
        chk("rst_out_vld", 128'(out_vld), 128'(0));
        chk("rst_out_pld", out_pld, 128'(0));
        chk("rst_out_row", 128'(out_row), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));

        // int8, all rows, no stalls
        gen_data(1);
        cap(1'b0, 16'hFFFF);
        run_drain(1'b0, 16'hFFFF, 1'b0);

        // int16, first and last row
        cap(1'b1, 16'h8001);
        run_drain(1'b1, 16'h8001, 1'b0);

        // int16 with random LSU stalls
        gen_data(3);
        cap(1'b1, 16'h0A50);
        run_drain(1'b1, 16'h0A50, 1'b1);

        // empty mask
        cap(1'b0, 16'h0000);
        chk("empty_done", 128'(done), 128'(1));
        chk("empty_vld", 128'(out_vld), 128'(0));
        chk("empty_cap_rdy", 128'(cap_rdy), 128'(1));
        tick();
        chk("empty_done_low", 128'(done), 128'(0));
        chk("empty_vld_low", 128'(out_vld), 128'(0));

        // overrun: capture attempt mid-drain must not disturb the buffer
        gen_data(5);
        cap(1'b1, 16'h0003);
        out_rdy        = 1'b0;
        cap_int8_data  = ~d8;
        cap_int16_data = ~d16;
        cap_mode       = 1'b0;
        cap_row_mask   = 16'hFFFF;
        cap_vld        = 1'b1;
        tick();
        cap_vld = 1'b0;
        chk("ovf_pulse", 128'(ovf), 128'(1));
        chk("ovf_cap_rdy", 128'(cap_rdy), 128'(0));
        chk("ovf_pld_hold", out_pld, d16[127:0]);
        tick();
        chk("ovf_one_cycle", 128'(ovf), 128'(0));
        run_drain(1'b1, 16'h0003, 1'b0);

        // clr after three beats, with a simultaneous capture attempt
        gen_data(7);
        cap(1'b0, 16'hFFFF);
        out_rdy = 1'b1;
        tick(); tick(); tick();
        chk("clr_pre_row", 128'(out_row), 128'(3));
        clr     = 1'b1;
        cap_vld = 1'b1;
        tick();
        clr     = 1'b0;
        cap_vld = 1'b0;
        chk("clr_vld", 128'(out_vld), 128'(0));
        chk("clr_no_done", 128'(done), 128'(0));
        chk("clr_no_ovf", 128'(ovf), 128'(0));
        chk("clr_cap_rdy", 128'(cap_rdy), 128'(1));
        tick();
        chk("clr_cap_ignored", 128'(out_vld), 128'(0));
        chk("clr_done_low", 128'(done), 128'(0));
        gen_data(9);
        cap(1'b0, 16'h0120);
        run_drain(1'b0, 16'h0120, 1'b0);

        // reset mid-drain
        cap(1'b1, 16'hFFFF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_vld", 128'(out_vld), 128'(0));
        chk("rst_mid_done", 128'(done), 128'(0));
        chk("rst_mid_cap_rdy", 128'(cap_rdy), 128'(1));
        chk("rst_mid_pld", out_pld, 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
